// File: rtl/pq_pkg.sv
// Shared constants and fetch FSM encoding for the instruction prefetch queue.
package pq_pkg;

  localparam int unsigned PQ_AW    = 16;
  localparam int unsigned PQ_IW    = 32;
  localparam int unsigned PQ_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pq_fifo.sv
// Instruction storage ring: DEPTH entries, head presented combinationally,
// clear takes priority over push and pop.
module pq_fifo
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH = PQ_DEPTH,
  parameter int unsigned IW    = PQ_IW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [IW-1:0] push_data,
  input  logic          pop_req,
  input  logic          clear,
  output logic [IW-1:0] head,
  output logic          head_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop_req && (count_q != '0);
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head       = mem_q[rptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: one outstanding bus fetch at a time feeding a small
// FIFO; a flush redirects the pc and drains any in-flight response.
module prefetch_queue
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH = PQ_DEPTH,
  parameter int unsigned IW    = PQ_IW,
  parameter int unsigned AW    = PQ_AW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_address,
  input  logic          fetch_ack,
  input  logic [IW-1:0] fetch_data,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_take,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          push_c;
  logic          clear_c;

  // Next-state: requests issue only from IDLE with a free slot, so every
  // accepted response is guaranteed room in the queue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push_c  = 1'b0;
    clear_c = flush;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          pc_d = flush_addr;
        end else if (count < CW'(DEPTH)) begin
          addr_d  = pc_q;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (flush) begin
          pc_d    = flush_addr;
          state_d = fetch_ack ? ST_IDLE : ST_DISCARD;
        end else if (fetch_ack) begin
          push_c  = 1'b1;
          pc_d    = pc_q + AW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (flush) begin
          pc_d = flush_addr;
        end
        if (fetch_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign fetch_req     = req_q;
  assign fetch_address = addr_q;

  pq_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_c),
    .push_data  (fetch_data),
    .pop_req    (ir_take),
    .clear      (clear_c),
    .head       (ir),
    .head_valid (ir_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue: a BIU model answers fetches, a
// queue-based reference predicts the instruction stream and fetch addresses.
module tb_prefetch_queue;
  import pq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_address;
  logic          fetch_ack;
  logic [IW-1:0] fetch_data;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          ir_take;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  prefetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_address (fetch_address),
    .fetch_ack     (fetch_ack),
    .fetch_data    (fetch_data),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_take       (ir_take),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  // Reference state: expected instruction queue, fetch pc, and whether the
  // in-flight response must be thrown away.
  logic [IW-1:0] sb[$];
  logic [AW-1:0] m_pc;
  bit            m_disc;
  bit            pend;
  int            lat;
  int            rst_left;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_req = 0;
  bit            prev_req;
  logic [AW-1:0] prev_addr;
  int            prev_cnt;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_pc   = '0;
    m_disc = 1'b0;
    pend   = 1'b0;
    lat    = 0;
  endfunction

  // Monitor: compares outputs mid-cycle and pops the scoreboard on each take.
  always @(negedge clk) begin : mon
    int sz;
    if (reset === 1'b0) begin
      chk("rst_fetch_req", 64'(fetch_req), 64'(0));
      chk("rst_fetch_addr", 64'(fetch_address), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_ir_valid", 64'(ir_valid), 64'(0));
      chk("rst_ir", 64'(ir), 64'(0));
      prev_req = 1'b0;
      prev_cnt = 0;
    end else begin
      sz = sb.size();
      chk("count", 64'(count), 64'(sz));
      chk("full", 64'(full), 64'(sz == DEPTH));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("ir_valid", 64'(ir_valid), 64'(sz != 0));
      if (fetch_req && !prev_req) begin
        n_req++;
        chk("req_addr", 64'(fetch_address), 64'(m_pc));
        chk("req_room", 64'(prev_cnt < DEPTH), 64'(1));
      end
      if (fetch_req && prev_req) begin
        chk("addr_stable", 64'(fetch_address), 64'(prev_addr));
      end
      if (ir_take && sz != 0) begin
        chk("ir_pop", 64'(ir), 64'(sb.pop_front()));
      end
      prev_req  = fetch_req;
      prev_addr = fetch_address;
      prev_cnt  = sz;
    end
  end

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 16'h0100;
      1:       return 16'h0200;
      2:       return 16'hFFFF;
      3:       return 16'hFFFE;
      default: return AW'($urandom);
    endcase
  endfunction

  // Driver: chooses inputs just after each edge, then advances the model
  // with the inputs that were sampled at that edge.
  initial begin : drv
    bit p;
    reset      = 1'b0;
    fetch_ack  = 1'b0;
    fetch_data = '0;
    ir_take    = 1'b0;
    flush      = 1'b0;
    flush_addr = '0;
    rst_left   = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 30) begin
        chk("fill_count", 64'(count), 64'(DEPTH));
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_no_req", 64'(fetch_req), 64'(0));
        chk("fill_req_num", 64'(n_req), 64'(4));
      end
      if (cyc >= 40) begin
        if (reset && $urandom_range(0, 199) == 0) begin
          reset    = 1'b0;
          rst_left = $urandom_range(1, 3);
          model_reset();
        end else if (!reset) begin
          if (rst_left == 0) reset = 1'b1;
          else rst_left--;
        end
      end
      fetch_data = IW'($urandom);
      fetch_ack  = 1'b0;
      if (!reset) begin
        fetch_ack = ($urandom_range(0, 1) == 1);
        ir_take   = ($urandom_range(0, 1) == 1);
        flush     = ($urandom_range(0, 3) == 0);
        flush_addr = pick_addr();
      end else begin
        if (fetch_req && !pend) begin
          pend = 1'b1;
          lat  = (cyc < 40) ? 1 : $urandom_range(0, 3);
        end
        if (pend) begin
          if (lat == 0) fetch_ack = 1'b1;
          else lat--;
        end else if (cyc >= 40 && $urandom_range(0, 29) == 0) begin
          fetch_ack = 1'b1;
        end
        if (cyc < 30) begin
          ir_take = 1'b0;
          flush   = 1'b0;
        end else if (cyc < 34) begin
          ir_take = 1'b1;
          flush   = 1'b0;
        end else if (cyc < 40) begin
          ir_take = 1'b0;
          flush   = 1'b0;
        end else begin
          ir_take    = ($urandom_range(0, 1) == 1);
          flush      = fetch_ack ? ($urandom_range(0, 4) == 0)
                                 : ($urandom_range(0, 11) == 0);
          flush_addr = pick_addr();
        end
      end
      @(posedge clk);
      #1;
      if (reset) begin
        p = pend;
        if (fetch_ack) pend = 1'b0;
        if (flush) begin
          sb.delete();
          m_pc   = flush_addr;
          m_disc = p && !fetch_ack;
        end else if (fetch_ack && p) begin
          if (!m_disc) begin
            sb.push_back(fetch_data);
            m_pc = m_pc + 16'd1;
          end
          m_disc = 1'b0;
        end
      end
    end
    chk("req_activity", 64'(n_req > 100), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 Parameter IW, default 32, instruction word width.
REQ-003 Parameter AW, default 16, fetch address width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fetch_req  output  1  request one instruction word from the bus interface.
REQ-007 fetch_address  output  AW  word address of the outstanding request.
REQ-008 fetch_ack  input  1  one-cycle pulse, fetch_data valid.
REQ-009 fetch_data  input  IW  returned instruction word.
REQ-010 ir  output  IW  head-of-queue instruction presented to the decoder.
REQ-011 ir_valid  output  1  queue non-empty, ir meaningful.
REQ-012 ir_take  input  1  decoder consumes the head entry this cycle.
REQ-013 flush  input  1  redirect pulse (branch/jump): discard the queue, restart fetch.
REQ-014 flush_addr  input  AW  new fetch address, sampled when flush=1.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 full, empty  output  1 each  count==DEPTH and count==0.

Function
REQ-017 Fetch FSM states: IDLE, FETCH, DISCARD; at most one request outstanding.
REQ-018 IDLE: if flush, pc<=flush_addr and stay IDLE; else if count<DEPTH, latch fetch_address<=pc and enter FETCH.
REQ-019 FETCH: fetch_req=1 and fetch_address stable until fetch_ack.
REQ-020 FETCH with fetch_ack and no flush: push fetch_data, pc<=pc+1 (wraps 2^AW-1 to 0), return to IDLE.
REQ-021 FETCH with flush and no fetch_ack: clear queue, pc<=flush_addr, enter DISCARD.
REQ-022 FETCH with flush and fetch_ack in the same cycle: drop fetch_data, clear queue, pc<=flush_addr, return to IDLE.
REQ-023 DISCARD: fetch_req stays 1 with the old fetch_address; on fetch_ack drop the data and return to IDLE.
REQ-024 Flush during DISCARD: pc<=newest flush_addr; remain in DISCARD until the pending ack.
REQ-025 A request is issued only when count<DEPTH, so the response always has a free slot.
REQ-026 Push latency: ack in cycle N makes the entry visible at ir/ir_valid in cycle N+1.
REQ-027 ir_take with ir_valid=1 pops the head; ir_take with empty queue is ignored.
REQ-028 Push and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-029 flush and ir_take in the same cycle: flush wins, count<=0.
REQ-030 ir is driven combinationally from the head entry.
REQ-031 Read and write pointers wrap modulo DEPTH.

Reset
REQ-032 On reset low: state IDLE, pc=0, fetch_address=0, pointers=0, count=0, fetch_req=0, ir_valid=0, empty=1, full=0, storage cleared so ir=0.
REQ-033 Reset asserted mid-fetch abandons the request without entering DISCARD; an ack arriving while in reset or in IDLE is ignored.
REQ-034 Fetching resumes from address 0 on the first rising edge after reset deasserts.

Structure
REQ-035 Shared package pq_pkg holds the FSM state encoding and the AW/IW default constants.
REQ-036 Storage, pointers and count live in one sub-module pq_fifo; prefetch_queue holds the FSM, pc and request register.

Verification
REQ-037 Reset release, BIU acks every request 2 cycles after fetch_req, no ir_take -> addresses 0,1,2,3 requested; full=1 with count=4; fetch_req stays 0.
REQ-038 Full queue, ir_take held high for 4 cycles -> ir returns words in order 0,1,2,3; a refill request at address 4 follows the first pop.
REQ-039 flush with flush_addr=0x0100 while FETCH is pending at 0x0002 -> DISCARD; the ack at 0x0002 is dropped; next request is 0x0100; count=0 immediately after flush.
REQ-040 flush with flush_addr=0x0200 in the same cycle as fetch_ack -> data not pushed; next fetch_address=0x0200.
REQ-041 flush=1 and fetch_ack=1 in the same cycle at pc=0xFFFF -> data dropped, pc=flush_addr; separately, normal ack at 0xFFFF -> next request at 0x0000.
REQ-042 count=2 with a simultaneous ack and ir_take -> count stays 2 and order is preserved; reset pulsed mid-FETCH -> all outputs at their reset values and the next request is at 0x0000.
